// File: rtl/mem_fifo_ctrl_if.sv
// Stream and RAM-port bundle for mem_fifo_ctrl: write stream, read stream,
// external dual-port RAM signals and the occupancy report.
interface mem_fifo_ctrl_if #(
  parameter int DATA_WIDTH = 14,
  parameter int ADDR_WIDTH = 6
);
  logic [DATA_WIDTH-1:0] in_data;
  logic                  in_valid;
  logic                  in_ready;
  logic [DATA_WIDTH-1:0] out_data;
  logic                  out_valid;
  logic                  out_ready;
  logic [ADDR_WIDTH-1:0] mem_wr_addr;
  logic [DATA_WIDTH-1:0] mem_wr_data;
  logic                  mem_wr_en;
  logic [ADDR_WIDTH-1:0] mem_rd_addr;
  logic [DATA_WIDTH-1:0] mem_rd_data;
  logic [ADDR_WIDTH+1:0] level;

  // Controller side
  modport master (
    input  in_data, in_valid, out_ready, mem_rd_data,
    output in_ready, out_data, out_valid,
    output mem_wr_addr, mem_wr_data, mem_wr_en, mem_rd_addr, level
  );

  // Producer / consumer / RAM side
  modport slave (
    output in_data, in_valid, out_ready, mem_rd_data,
    input  in_ready, out_data, out_valid,
    input  mem_wr_addr, mem_wr_data, mem_wr_en, mem_rd_addr, level
  );
endinterface

// File: rtl/mem_fifo_ctrl.sv
// Streaming FIFO controller around an external simple dual-port RAM with a
// synchronous read port; a 2-entry output buffer hides the read latency.
module mem_fifo_ctrl #(
  parameter int DATA_WIDTH = 14,
  parameter int ADDR_WIDTH = 6
) (
  input  logic              clk,
  input  logic              rst,
  mem_fifo_ctrl_if.master   bus
);

  localparam logic [ADDR_WIDTH-1:0] PTR_ONE   = {{(ADDR_WIDTH-1){1'b0}}, 1'b1};
  localparam logic [ADDR_WIDTH:0]   CNT_ZERO  = {(ADDR_WIDTH+1){1'b0}};
  localparam logic [ADDR_WIDTH:0]   CNT_ONE   = {{ADDR_WIDTH{1'b0}}, 1'b1};
  localparam logic [ADDR_WIDTH:0]   DEPTH_CNT = {1'b1, {ADDR_WIDTH{1'b0}}};
  localparam logic [ADDR_WIDTH+1:0] LVL_ONE   = {{(ADDR_WIDTH+1){1'b0}}, 1'b1};

  logic [ADDR_WIDTH-1:0] wr_ptr_q, wr_ptr_d;
  logic [ADDR_WIDTH-1:0] rd_ptr_q, rd_ptr_d;
  logic [ADDR_WIDTH:0]   ram_cnt_q, ram_cnt_d;
  logic                  inflight_q, inflight_d;
  logic [1:0]            obuf_cnt_q, obuf_cnt_d;
  logic [DATA_WIDTH-1:0] obuf0_q, obuf0_d;
  logic [DATA_WIDTH-1:0] obuf1_q, obuf1_d;
  logic                  out_valid_q, out_valid_d;
  logic                  in_ready_q, in_ready_d;
  logic [ADDR_WIDTH+1:0] level_q, level_d;

  logic                  push_s;
  logic                  pop_s;
  logic                  issue_s;
  logic [2:0]            obuf_load_s;
  logic [1:0]            cnt_after_pop_s;
  logic [DATA_WIDTH-1:0] head_after_pop_s;

  assign push_s = bus.in_valid & bus.in_ready;
  assign pop_s  = out_valid_q & bus.out_ready;

  // A same-cycle pop frees a buffer slot, so it is credited here; without
  // that credit the read pipeline stalls every other cycle when streaming.
  assign obuf_load_s = {1'b0, obuf_cnt_q} + {2'b00, inflight_q} - {2'b00, pop_s};
  assign issue_s     = (ram_cnt_q != CNT_ZERO) && (obuf_load_s < 3'd2);

  assign cnt_after_pop_s  = obuf_cnt_q - {1'b0, pop_s};
  assign head_after_pop_s = pop_s ? obuf1_q : obuf0_q;

  // Next-state computation for pointers, counters and the output buffer
  always_comb begin
    if (push_s) begin
      wr_ptr_d = wr_ptr_q + PTR_ONE;
    end else begin
      wr_ptr_d = wr_ptr_q;
    end

    if (issue_s) begin
      rd_ptr_d = rd_ptr_q + PTR_ONE;
    end else begin
      rd_ptr_d = rd_ptr_q;
    end
    inflight_d = issue_s;

    case ({push_s, issue_s})
      2'b10:   ram_cnt_d = ram_cnt_q + CNT_ONE;
      2'b01:   ram_cnt_d = ram_cnt_q - CNT_ONE;
      default: ram_cnt_d = ram_cnt_q;
    endcase

    case ({push_s, pop_s})
      2'b10:   level_d = level_q + LVL_ONE;
      2'b01:   level_d = level_q - LVL_ONE;
      default: level_d = level_q;
    endcase

    // Returning read data lands in the first free slot after any pop shift.
    if (inflight_q) begin
      if (cnt_after_pop_s == 2'd0) begin
        obuf0_d = bus.mem_rd_data;
        obuf1_d = obuf1_q;
      end else begin
        obuf0_d = head_after_pop_s;
        obuf1_d = bus.mem_rd_data;
      end
    end else begin
      obuf0_d = head_after_pop_s;
      obuf1_d = obuf1_q;
    end
    obuf_cnt_d = cnt_after_pop_s + {1'b0, inflight_q};

    out_valid_d = (obuf_cnt_d != 2'd0);
    in_ready_d  = (ram_cnt_d != DEPTH_CNT);
  end

  // State registers; reset discards all contents and any in-flight read
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr_q    <= {ADDR_WIDTH{1'b0}};
      rd_ptr_q    <= {ADDR_WIDTH{1'b0}};
      ram_cnt_q   <= CNT_ZERO;
      inflight_q  <= 1'b0;
      obuf_cnt_q  <= 2'd0;
      obuf0_q     <= {DATA_WIDTH{1'b0}};
      obuf1_q     <= {DATA_WIDTH{1'b0}};
      out_valid_q <= 1'b0;
      in_ready_q  <= 1'b1;
      level_q     <= {(ADDR_WIDTH+2){1'b0}};
    end else begin
      wr_ptr_q    <= wr_ptr_d;
      rd_ptr_q    <= rd_ptr_d;
      ram_cnt_q   <= ram_cnt_d;
      inflight_q  <= inflight_d;
      obuf_cnt_q  <= obuf_cnt_d;
      obuf0_q     <= obuf0_d;
      obuf1_q     <= obuf1_d;
      out_valid_q <= out_valid_d;
      in_ready_q  <= in_ready_d;
      level_q     <= level_d;
    end
  end

  // in_ready resets high internally but is masked while reset is held.
  assign bus.in_ready    = in_ready_q & ~rst;
  assign bus.out_valid   = out_valid_q;
  assign bus.out_data    = obuf0_q;
  assign bus.mem_wr_en   = push_s;
  assign bus.mem_wr_addr = wr_ptr_q;
  assign bus.mem_wr_data = bus.in_data;
  assign bus.mem_rd_addr = rd_ptr_q;
  assign bus.level       = level_q;

endmodule

// File: tb/tb_mem_fifo_ctrl.sv
// Self-checking bench for mem_fifo_ctrl: RAM model plus a queue-based
// reference FIFO; directed latency/fill/drain/stream cases then random traffic.
module tb_mem_fifo_ctrl;
  localparam int DW    = 14;
  localparam int AW    = 6;
  localparam int DEPTH = 64;
  localparam int CAP   = DEPTH + 2;

  logic clk;
  logic rst;

  mem_fifo_ctrl_if #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW)) bus ();

  mem_fifo_ctrl #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus.master)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // External RAM: synchronous write, one-cycle registered read
  logic [DW-1:0] ram [DEPTH];
  always @(posedge clk) begin
    if (bus.mem_wr_en) ram[bus.mem_wr_addr] <= bus.mem_wr_data;
    bus.mem_rd_data <= ram[bus.mem_rd_addr];
  end

  int n_checks = 0;
  int n_pass   = 0;
  int n_pops   = 0;
  logic [DW-1:0] model_q [$];

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) begin
      n_pass++;
    end else begin
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // One clock: record the handshakes that happen at this edge, advance the
  // reference queue, then check outputs just after the edge.
  task automatic cycle();
    bit push, pop, stalled;
    logic [DW-1:0] sdata;
    push    = bus.in_valid && bus.in_ready;
    pop     = bus.out_valid && bus.out_ready;
    stalled = bus.out_valid && !bus.out_ready;
    sdata   = bus.out_data;
    if (pop) begin
      n_pops++;
      if (model_q.size() == 0) begin
        chk("pop_when_empty", 32'd1, 32'd0);
      end else begin
        chk("pop_data", 32'(bus.out_data), 32'(model_q[0]));
        void'(model_q.pop_front());
      end
    end
    if (push) model_q.push_back(bus.in_data);
    @(posedge clk);
    #1;
    chk("level", 32'(bus.level), 32'(model_q.size()));
    if (stalled) begin
      chk("stall_valid", 32'(bus.out_valid), 32'd1);
      chk("stall_data", 32'(bus.out_data), 32'(sdata));
    end
    if (model_q.size() < DEPTH) chk("in_ready_room", 32'(bus.in_ready), 32'd1);
    else if (model_q.size() == CAP) chk("in_ready_full", 32'(bus.in_ready), 32'd0);
  endtask

  initial begin
    int sent, got, cycles, first_k, bubbles, pops0;
    bit first_seen;

    rst           = 1'b1;
    bus.in_data   = '0;
    bus.in_valid  = 1'b0;
    bus.out_ready = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_level", 32'(bus.level), 32'd0);
    chk("rst_ovalid", 32'(bus.out_valid), 32'd0);
    chk("rst_in_ready", 32'(bus.in_ready), 32'd0);
    rst = 1'b0;
    #1;
    chk("rel_in_ready", 32'(bus.in_ready), 32'd1);

    // 1: reset in the middle of traffic
    bus.in_valid = 1'b1;
    for (int i = 0; i < 6; i++) begin
      bus.in_data = DW'(i + 14'h100);
      cycle();
    end
    bus.out_ready = 1'b1;
    cycle();
    rst = 1'b1;
    #1;
    for (int i = 0; i < 3; i++) begin
      chk("mid_rst_in_ready", 32'(bus.in_ready), 32'd0);
      chk("mid_rst_ovalid", 32'(bus.out_valid), 32'd0);
      chk("mid_rst_level", 32'(bus.level), 32'd0);
      @(posedge clk);
      #1;
    end
    bus.in_valid  = 1'b0;
    bus.out_ready = 1'b0;
    rst = 1'b0;
    model_q.delete();
    #1;
    chk("post_rst_in_ready", 32'(bus.in_ready), 32'd1);
    chk("post_rst_ovalid", 32'(bus.out_valid), 32'd0);
    chk("post_rst_level", 32'(bus.level), 32'd0);
    repeat (3) cycle();
    chk("post_rst_still_empty", 32'(bus.out_valid), 32'd0);

    // 2: single word latency
    bus.in_data   = 14'h1A5;
    bus.in_valid  = 1'b1;
    bus.out_ready = 1'b1;
    cycle();
    bus.in_valid = 1'b0;
    chk("lat_edge0", 32'(bus.out_valid), 32'd0);
    cycle();
    chk("lat_edge1", 32'(bus.out_valid), 32'd0);
    cycle();
    chk("lat_edge2_valid", 32'(bus.out_valid), 32'd1);
    chk("lat_edge2_data", 32'(bus.out_data), 32'h1A5);
    cycle();
    chk("single_level", 32'(bus.level), 32'd0);
    chk("single_ovalid", 32'(bus.out_valid), 32'd0);

    // 3: fill to capacity with consumer stalled
    bus.out_ready = 1'b0;
    bus.in_valid  = 1'b1;
    for (int i = 0; i < CAP; i++) begin
      bus.in_data = DW'(i);
      chk("fill_accept", 32'(bus.in_ready), 32'd1);
      cycle();
    end
    chk("full_in_ready", 32'(bus.in_ready), 32'd0);
    chk("full_level", 32'(bus.level), 32'(CAP));
    chk("full_ovalid", 32'(bus.out_valid), 32'd1);
    chk("full_head", 32'(bus.out_data), 32'd0);
    bus.in_data = 14'h3FFF;
    repeat (2) cycle();
    chk("refused_level", 32'(bus.level), 32'(CAP));
    bus.in_valid = 1'b0;

    // 4: drain in order, back to back
    bus.out_ready = 1'b1;
    for (int i = 0; i < CAP; i++) begin
      chk("drain_valid", 32'(bus.out_valid), 32'd1);
      chk("drain_data", 32'(bus.out_data), 32'(i));
      cycle();
      if (i == 0) chk("drain_in_ready", 32'(bus.in_ready), 32'd1);
    end
    chk("drained_ovalid", 32'(bus.out_valid), 32'd0);
    chk("drained_level", 32'(bus.level), 32'd0);

    // 5: streaming with pointer wrap
    sent = 0; got = 0; cycles = 0; first_k = -1; bubbles = 0; first_seen = 1'b0;
    bus.out_ready = 1'b1;
    while (got < 200 && cycles < 1000) begin
      bus.in_valid = (sent < 200);
      bus.in_data  = DW'(sent);
      if (bus.out_valid) begin
        if (!first_seen) begin
          first_seen = 1'b1;
          first_k    = cycles;
        end
        got++;
      end else if (first_seen) begin
        bubbles++;
      end
      if (bus.in_valid && bus.in_ready) sent++;
      cycle();
      cycles++;
    end
    bus.in_valid = 1'b0;
    chk("stream_latency", 32'(first_k), 32'd3);
    chk("stream_bubbles", 32'(bubbles), 32'd0);
    chk("stream_sent", 32'(sent), 32'd200);
    chk("stream_got", 32'(got), 32'd200);
    chk("stream_level", 32'(bus.level), 32'd0);

    // 6: random backpressure on both sides
    pops0 = n_pops; cycles = 0;
    while ((n_pops - pops0) < 1000 && cycles < 20000) begin
      bus.in_valid  = 1'($urandom_range(0, 1));
      bus.in_data   = DW'($urandom);
      bus.out_ready = 1'($urandom_range(0, 1));
      cycle();
      cycles++;
    end
    chk("bp_words_done", 32'((n_pops - pops0) >= 1000), 32'd1);

    bus.in_valid  = 1'b0;
    bus.out_ready = 1'b1;
    cycles = 0;
    while (model_q.size() != 0 && cycles < 200) begin
      cycle();
      cycles++;
    end
    chk("final_empty_ovalid", 32'(bus.out_valid), 32'd0);
    chk("final_level", 32'(bus.level), 32'd0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end
endmodule
